// File: rtl/ahb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: AHB transfer/response codes
// and the error-response FSM state type.
package ahb_bridge_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic [1:0] HrespOkay  = 2'b00;
  localparam logic [1:0] HrespError = 2'b01;

  typedef enum logic [1:0] {
    StOk   = 2'b00,
    StErr1 = 2'b01,
    StErr2 = 2'b10
  } err_state_e;

endpackage

// File: rtl/ahb_slave_frontend_p_if.sv
// AHB-side bus bundle of the bridge front end; the slave modport is the
// front end's view, the master modport is the interconnect/controller view.
interface ahb_slave_frontend_p_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 3
) ();

  logic              h_write;
  logic              h_readyin;
  logic [1:0]        h_trans;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_readyout;
  logic [DATA_W-1:0] p_rdata;

  logic [DATA_W-1:0]  h_rdata;
  logic [1:0]         h_resp;
  logic               h_ready_o;
  logic               valid;
  logic [ADDR_W-1:0]  h_addr1;
  logic [ADDR_W-1:0]  h_addr2;
  logic [DATA_W-1:0]  h_wdata1;
  logic [DATA_W-1:0]  h_wdata2;
  logic               writereg;
  logic [NUM_SLV-1:0] tempsel;

  modport slave (
    input  h_write, h_readyin, h_trans, h_addr, h_wdata, h_readyout, p_rdata,
    output h_rdata, h_resp, h_ready_o, valid, h_addr1, h_addr2, h_wdata1, h_wdata2,
           writereg, tempsel
  );

  modport master (
    output h_write, h_readyin, h_trans, h_addr, h_wdata, h_readyout, p_rdata,
    input  h_rdata, h_resp, h_ready_o, valid, h_addr1, h_addr2, h_wdata1, h_wdata2,
           writereg, tempsel
  );

endinterface

// File: rtl/ahb_addr_decode.sv
// Maps an address onto NUM_SLV contiguous 2^SLV_AW regions starting at BASE_ADDR.
// Purely combinational; shared with the APB controller for PSEL generation.
module ahb_addr_decode #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       NUM_SLV   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned       SLV_AW    = 26
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               hit_o,
  output logic [NUM_SLV-1:0] sel_o
);

  // One extra bit so a map ending exactly at the top of the space does not wrap.
  localparam int unsigned     ExtW  = ADDR_W + 1;
  localparam logic [ExtW-1:0] Base  = {1'b0, BASE_ADDR};
  localparam logic [ExtW-1:0] Limit = Base + (ExtW'(NUM_SLV) << SLV_AW);

  logic [ExtW-1:0] addr_ext;
  logic [ExtW-1:0] region;

  always_comb begin
    addr_ext = {1'b0, addr_i};
    region   = (addr_ext - Base) >> SLV_AW;
    hit_o    = (addr_ext >= Base) && (addr_ext < Limit);
    sel_o    = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (hit_o && (region == ExtW'(i))) begin
        sel_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_frontend_p.sv
// AHB front end of the AHB-to-APB bridge: qualifies and decodes transfers,
// pipelines address/data/direction and issues the two-cycle ERROR response.
module ahb_slave_frontend_p #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_SLV   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned       SLV_AW    = 26
) (
  input logic                   h_clk,
  input logic                   h_reset,
  ahb_slave_frontend_p_if.slave bus
);
  import ahb_bridge_pkg::*;

  logic       hit;
  logic       active;
  logic       unmapped;
  err_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DATA_W-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;
  logic              write_q, write_d;

  ahb_addr_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_SLV  (NUM_SLV),
    .BASE_ADDR(BASE_ADDR),
    .SLV_AW   (SLV_AW)
  ) u_decode (
    .addr_i(bus.h_addr),
    .hit_o (hit),
    .sel_o (bus.tempsel)
  );

  always_comb begin
    active   = bus.h_readyin && bus.h_trans[1];
    unmapped = active && !hit;
    state_d  = StOk;
    unique case (state_q)
      StOk:    state_d = unmapped ? StErr1 : StOk;
      StErr1:  state_d = StErr2;
      // A new unmapped phase in the second error cycle restarts the response.
      StErr2:  state_d = unmapped ? StErr1 : StOk;
      default: state_d = StOk;
    endcase
  end

  // Pipeline advances only when the APB side is ready; otherwise it holds.
  always_comb begin
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    wdata1_d = wdata1_q;
    wdata2_d = wdata2_q;
    write_d  = write_q;
    if (bus.h_readyout) begin
      addr1_d  = bus.h_addr;
      addr2_d  = addr1_q;
      wdata1_d = bus.h_wdata;
      wdata2_d = wdata1_q;
      write_d  = bus.h_write;
    end
  end

  always_ff @(posedge h_clk or negedge h_reset) begin
    if (!h_reset) begin
      state_q  <= StOk;
      addr1_q  <= '0;
      addr2_q  <= '0;
      wdata1_q <= '0;
      wdata2_q <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      wdata1_q <= wdata1_d;
      wdata2_q <= wdata2_d;
      write_q  <= write_d;
    end
  end

  always_comb begin
    bus.valid     = active && hit;
    bus.h_rdata   = bus.p_rdata;
    bus.h_addr1   = addr1_q;
    bus.h_addr2   = addr2_q;
    bus.h_wdata1  = wdata1_q;
    bus.h_wdata2  = wdata2_q;
    bus.writereg  = write_q;
    bus.h_resp    = (state_q == StOk) ? HrespOkay : HrespError;
    bus.h_ready_o = (state_q == StErr1) ? 1'b0 :
                    (state_q == StErr2) ? 1'b1 : bus.h_readyout;
  end

endmodule

// File: tb/tb_ahb_slave_frontend_p.sv
// Self-checking bench for ahb_slave_frontend_p: decode table, directed
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_ahb_slave_frontend_p;
  import ahb_bridge_pkg::*;

  localparam longint unsigned Base = 64'h8000_0000;

  logic h_clk;
  logic h_reset;
  int   n_cmp = 0;
  int   n_err = 0;

  ahb_slave_frontend_p_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3))  ifa ();
  ahb_slave_frontend_p_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(16)) ifb ();

  ahb_slave_frontend_p #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .BASE_ADDR(32'h8000_0000), .SLV_AW(26)
  ) dut (
    .h_clk  (h_clk),
    .h_reset(h_reset),
    .bus    (ifa)
  );

  ahb_slave_frontend_p #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(16), .BASE_ADDR(32'h8000_0000), .SLV_AW(27)
  ) dut16 (
    .h_clk  (h_clk),
    .h_reset(h_reset),
    .bus    (ifb)
  );

  initial begin
    h_clk = 1'b0;
    forever #5 h_clk = ~h_clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        readyin;
    logic        exp_valid;
    logic [2:0]  exp_sel;
  } dec_vec_t;

  dec_vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_a(input logic [31:0] addr, input logic [1:0] trans, input logic wr,
                         input logic [31:0] wdata, input logic rdyin, input logic rdyout);
    ifa.h_addr     = addr;
    ifa.h_trans    = trans;
    ifa.h_write    = wr;
    ifa.h_wdata    = wdata;
    ifa.h_readyin  = rdyin;
    ifa.h_readyout = rdyout;
  endtask

  task automatic do_reset();
    @(negedge h_clk);
    h_reset = 1'b0;
    @(negedge h_clk);
    h_reset = 1'b1;
  endtask

  // Reference model state: error phase 0=none, 1=first, 2=second error cycle.
  longint unsigned m_a1, m_a2, m_w1, m_w2;
  bit              m_wr;
  int              m_phase;

  initial begin
    logic [31:0] a1_hold, a2_hold, w1_hold, w2_hold;
    longint unsigned a;
    bit hit, act;
    longint unsigned idx;
    logic [2:0] exp_sel;
    logic [1:0] exp_resp;
    logic exp_rdy;

    tbl[0] = '{32'h8000_0000, HtransNonseq, 1'b1, 1'b1, 3'b001};
    tbl[1] = '{32'h83FF_FFFC, HtransSeq,    1'b1, 1'b1, 3'b001};
    tbl[2] = '{32'h8400_0000, HtransNonseq, 1'b1, 1'b1, 3'b010};
    tbl[3] = '{32'h8BFF_FFFC, HtransSeq,    1'b1, 1'b1, 3'b100};
    tbl[4] = '{32'h8C00_0000, HtransNonseq, 1'b1, 1'b0, 3'b000};
    tbl[5] = '{32'h7FFF_FFFC, HtransNonseq, 1'b1, 1'b0, 3'b000};
    tbl[6] = '{32'h8000_0000, HtransIdle,   1'b1, 1'b0, 3'b001};
    tbl[7] = '{32'h8400_0000, HtransBusy,   1'b1, 1'b0, 3'b010};
    tbl[8] = '{32'h8800_0000, HtransNonseq, 1'b0, 1'b0, 3'b100};
    tbl[9] = '{32'h0000_0000, HtransSeq,    1'b1, 1'b0, 3'b000};

    ifb.h_addr = '0; ifb.h_trans = HtransIdle; ifb.h_write = 1'b0; ifb.h_wdata = '0;
    ifb.h_readyin = 1'b1; ifb.h_readyout = 1'b1; ifb.p_rdata = '0;
    ifa.p_rdata = '0;

    // Reset state with a mapped NONSEQ already on the bus.
    h_reset = 1'b0;
    drive_a(32'h8000_0010, HtransNonseq, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    #2;
    chk("rst_addr1", ifa.h_addr1, 0);
    chk("rst_addr2", ifa.h_addr2, 0);
    chk("rst_wdata1", ifa.h_wdata1, 0);
    chk("rst_wdata2", ifa.h_wdata2, 0);
    chk("rst_writereg", ifa.writereg, 0);
    chk("rst_resp", ifa.h_resp, HrespOkay);
    chk("rst_ready", ifa.h_ready_o, 1);
    chk("rst_valid", ifa.valid, 1);
    chk("rst_sel", ifa.tempsel, 3'b001);
    @(negedge h_clk);
    h_reset = 1'b1;

    // Combinational decode table.
    for (int i = 0; i < 10; i++) begin
      @(negedge h_clk);
      drive_a(tbl[i].addr, tbl[i].trans, 1'b0, '0, tbl[i].readyin, 1'b1);
      ifa.p_rdata = 32'h1234_0000 + 32'(i);
      #1;
      chk($sformatf("tbl%0d_valid", i), ifa.valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_sel", i), ifa.tempsel, tbl[i].exp_sel);
      chk($sformatf("tbl%0d_rdata", i), ifa.h_rdata, 32'h1234_0000 + 32'(i));
    end
    drive_a('0, HtransIdle, 1'b0, '0, 1'b1, 1'b1);
    do_reset();

    // Mapped write flows through the pipeline.
    drive_a(32'h8400_0004, HtransNonseq, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1);
    #1;
    chk("wr_sel", ifa.tempsel, 3'b010);
    chk("wr_valid", ifa.valid, 1);
    @(posedge h_clk); #1;
    chk("wr_addr1", ifa.h_addr1, 32'h8400_0004);
    chk("wr_writereg", ifa.writereg, 1);
    chk("wr_wdata1", ifa.h_wdata1, 32'hA5A5_0001);
    drive_a(32'h0, HtransIdle, 1'b0, 32'h0000_0BAD, 1'b1, 1'b1);
    @(posedge h_clk); #1;
    chk("wr_wdata2", ifa.h_wdata2, 32'hA5A5_0001);
    chk("wr_addr2", ifa.h_addr2, 32'h8400_0004);
    chk("wr_writereg0", ifa.writereg, 0);

    // Unmapped address one past the map: two-cycle ERROR.
    @(negedge h_clk);
    drive_a(32'h8C00_0000, HtransNonseq, 1'b0, '0, 1'b1, 1'b1);
    #1;
    chk("um_valid", ifa.valid, 0);
    chk("um_sel", ifa.tempsel, 0);
    chk("um_resp0", ifa.h_resp, HrespOkay);
    @(posedge h_clk); #1;
    drive_a(32'h0, HtransIdle, 1'b0, '0, 1'b1, 1'b1);
    chk("um_resp1", ifa.h_resp, HrespError);
    chk("um_rdy1", ifa.h_ready_o, 0);
    @(posedge h_clk); #1;
    chk("um_resp2", ifa.h_resp, HrespError);
    chk("um_rdy2", ifa.h_ready_o, 1);
    @(posedge h_clk); #1;
    chk("um_resp3", ifa.h_resp, HrespOkay);
    chk("um_rdy3", ifa.h_ready_o, 1);

    // Back-to-back unmapped: ERR1, ERR2, ERR1, ERR2.
    drive_a(32'h1000_0000, HtransNonseq, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge h_clk); #1;
      chk($sformatf("b2b%0d_resp", i), ifa.h_resp, HrespError);
      chk($sformatf("b2b%0d_rdy", i), ifa.h_ready_o, (i % 2 == 1) ? 1 : 0);
    end
    drive_a(32'h0, HtransIdle, 1'b0, '0, 1'b1, 1'b1);
    @(posedge h_clk); #1;
    chk("b2b_end_resp", ifa.h_resp, HrespOkay);

    // Top-of-space map with 16 regions of 128 MiB.
    @(negedge h_clk);
    ifb.h_addr = 32'h7FFF_FFFC; ifb.h_trans = HtransNonseq;
    #1;
    chk("top_lo_valid", ifb.valid, 0);
    chk("top_lo_sel", ifb.tempsel, 0);
    @(posedge h_clk); #1;
    chk("top_lo_resp", ifb.h_resp, HrespError);
    ifb.h_addr = 32'hFFFF_FFFC;
    #1;
    chk("top_hi_valid", ifb.valid, 1);
    chk("top_hi_sel", ifb.tempsel, 16'h8000);
    ifb.h_trans = HtransIdle;

    // Pipeline holds while h_readyout is low; unmapped still errors.
    @(negedge h_clk);
    a1_hold = ifa.h_addr1; a2_hold = ifa.h_addr2;
    w1_hold = ifa.h_wdata1; w2_hold = ifa.h_wdata2;
    drive_a(32'h8800_0000, HtransNonseq, 1'b1, 32'h5A5A_7777, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge h_clk); #1;
      chk($sformatf("hold%0d_addr1", i), ifa.h_addr1, a1_hold);
      chk($sformatf("hold%0d_addr2", i), ifa.h_addr2, a2_hold);
      chk($sformatf("hold%0d_wdata1", i), ifa.h_wdata1, w1_hold);
      chk($sformatf("hold%0d_wdata2", i), ifa.h_wdata2, w2_hold);
    end
    ifa.h_readyout = 1'b1;
    @(posedge h_clk); #1;
    chk("hold_rel_addr1", ifa.h_addr1, 32'h8800_0000);
    chk("hold_rel_addr2", ifa.h_addr2, a1_hold);
    chk("hold_rel_wdata1", ifa.h_wdata1, 32'h5A5A_7777);
    drive_a(32'h0000_0040, HtransNonseq, 1'b0, '0, 1'b1, 1'b0);
    @(posedge h_clk); #1;
    chk("hold_um_resp", ifa.h_resp, HrespError);
    chk("hold_um_rdy", ifa.h_ready_o, 0);
    chk("hold_um_addr1", ifa.h_addr1, 32'h8800_0000);

    // Async reset in the first error cycle aborts the response.
    drive_a(32'h0, HtransIdle, 1'b0, '0, 1'b1, 1'b1);
    @(posedge h_clk); #1;
    drive_a(32'h0900_0000, HtransNonseq, 1'b0, '0, 1'b1, 1'b1);
    @(posedge h_clk); #1;
    chk("ar_resp_err1", ifa.h_resp, HrespError);
    chk("ar_rdy_err1", ifa.h_ready_o, 0);
    drive_a(32'h0, HtransIdle, 1'b0, '0, 1'b1, 1'b1);
    #1 h_reset = 1'b0;
    #1;
    chk("ar_resp", ifa.h_resp, HrespOkay);
    chk("ar_rdy", ifa.h_ready_o, 1);
    @(negedge h_clk);
    h_reset = 1'b1;
    @(posedge h_clk); #1;
    chk("ar_post_resp", ifa.h_resp, HrespOkay);

    // Randomized traffic against the reference model.
    do_reset();
    m_a1 = 0; m_a2 = 0; m_w1 = 0; m_w2 = 0; m_wr = 0; m_phase = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge h_clk);
      case ($urandom_range(0, 3))
        0:       ifa.h_addr = 32'h8000_0000 + $urandom_range(0, 32'h0BFF_FFFF);
        1:       ifa.h_addr = 32'h8BFF_FFF0 + $urandom_range(0, 31);
        2:       ifa.h_addr = 32'h7FFF_FFF0 + $urandom_range(0, 31);
        default: ifa.h_addr = $urandom;
      endcase
      ifa.h_trans    = 2'($urandom_range(0, 3));
      ifa.h_write    = 1'($urandom);
      ifa.h_wdata    = $urandom;
      ifa.p_rdata    = $urandom;
      ifa.h_readyin  = ($urandom_range(0, 4) != 0);
      ifa.h_readyout = ($urandom_range(0, 3) != 0);
      #1;
      a   = 64'(ifa.h_addr);
      hit = (a >= Base) && (a < Base + (64'd3 << 26));
      act = ifa.h_readyin && (ifa.h_trans == HtransNonseq || ifa.h_trans == HtransSeq);
      idx = (a - Base) >> 26;
      exp_sel  = hit ? 3'(1 << idx) : 3'b000;
      exp_resp = (m_phase != 0) ? HrespError : HrespOkay;
      exp_rdy  = (m_phase == 1) ? 1'b0 : (m_phase == 2) ? 1'b1 : ifa.h_readyout;
      chk("rnd_valid", ifa.valid, act && hit);
      chk("rnd_sel", ifa.tempsel, exp_sel);
      chk("rnd_rdata", ifa.h_rdata, ifa.p_rdata);
      chk("rnd_resp", ifa.h_resp, exp_resp);
      chk("rnd_rdy", ifa.h_ready_o, exp_rdy);
      @(posedge h_clk);
      if (m_phase == 1)       m_phase = 2;
      else if (act && !hit)   m_phase = 1;
      else                    m_phase = 0;
      if (ifa.h_readyout) begin
        m_a2 = m_a1; m_a1 = a;
        m_w2 = m_w1; m_w1 = 64'(ifa.h_wdata);
        m_wr = ifa.h_write;
      end
      #1;
      chk("rnd_addr1", ifa.h_addr1, m_a1);
      chk("rnd_addr2", ifa.h_addr2, m_a2);
      chk("rnd_wdata1", ifa.h_wdata1, m_w1);
      chk("rnd_wdata2", ifa.h_wdata2, m_w2);
      chk("rnd_writereg", ifa.writereg, m_wr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_slave_frontend_p.md
# ahb_slave_frontend_p

Parametrised AHB-side front end of the AHB-to-APB bridge. It qualifies AHB transfers, decodes the address onto N APB slave regions, and pipelines address, write data and direction for the APB-side controller. It also generates the two-cycle AHB ERROR response for unmapped addresses. It sits between the AHB interconnect and the bridge's APB controller FSM.

## Interface
- ADDR_W, 32, AHB address width
- DATA_W, 32, AHB/APB data width
- NUM_SLV, 3, number of APB slave regions (1..16)
- BASE_ADDR, 32'h8000_0000, start of region 0 (ADDR_W bits, aligned to 2^SLV_AW)
- SLV_AW, 26, log2 of each region size (regions contiguous, 64 MiB default)

Ports:
- h_clk  in  1  bridge clock
- h_reset  in  1  asynchronous, active-low reset
- h_write  in  1  AHB HWRITE
- h_readyin  in  1  AHB HREADY (bus-level, fed back)
- h_trans  in  2  AHB HTRANS
- h_addr  in  ADDR_W  AHB HADDR
- h_wdata  in  DATA_W  AHB HWDATA
- h_readyout  in  1  APB controller ready (pipeline advance)
- p_rdata  in  DATA_W  read data from APB controller
- h_rdata  out  DATA_W  AHB HRDATA
- h_resp  out  2  AHB HRESP (00 OKAY, 01 ERROR)
- h_ready_o  out  1  HREADYOUT of this slave
- valid  out  1  qualified, mapped transfer in address phase
- h_addr1, h_addr2  out  ADDR_W  address pipeline stages 1/2
- h_wdata1, h_wdata2  out  DATA_W  write-data pipeline stages 1/2
- writereg  out  1  registered HWRITE aligned with h_addr1
- tempsel  out  NUM_SLV  one-hot slave select for current h_addr

## Operation
- hit = (h_addr >= BASE_ADDR) && (h_addr < BASE_ADDR + NUM_SLV<<SLV_AW).
  - Computed in ADDR_W+1 bits; no wrap at the top of the address space.
- idx = (h_addr - BASE_ADDR) >> SLV_AW; tempsel = hit ? (1<<idx) : 0. Combinational, never latched.
- active = h_readyin && h_trans[1] (NONSEQ 10 or SEQ 11). IDLE and BUSY are never active.
- valid = active && hit (combinational). Unmapped: valid = 0, transfer never forwarded.
- Pipeline regs (h_addr1/2, h_wdata1/2, writereg):
  - Update only when h_readyout = 1; hold otherwise.
  - h_addr1 <= h_addr, h_addr2 <= h_addr1, h_wdata1 <= h_wdata, h_wdata2 <= h_wdata1, writereg <= h_write.
- h_rdata = p_rdata (combinational pass-through).
- Error FSM, states OK, ERR1, ERR2:
  - OK -> ERR1 on clock edge with active && !hit.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> ERR1 if active && !hit on that edge; otherwise OK.
- h_resp: 01 in ERR1 and ERR2; 00 otherwise.
- h_ready_o: 0 in ERR1; 1 in ERR2; h_readyout in OK.

## Timing
- Reset (async, immediate):
  - All pipeline regs and writereg = 0.
  - FSM = OK, h_resp = 00, h_ready_o = h_readyout.
  - Reset in ERR1/ERR2 aborts the error response.
- valid and tempsel: zero-cycle latency from h_addr/h_trans.
- Pipeline: h_addr1 one h_readyout-qualified edge after the address phase; h_addr2 two such edges after.
- Error response: ERR1 occupies cycle 1 after the unmapped address phase, ERR2 cycle 2. Exactly two cycles of h_resp = 01.
- Address phase presented during ERR2 (h_readyin = 1) is evaluated normally. A mapped one asserts valid in that cycle.
- h_readyout = 0 while an unmapped address arrives: error FSM still advances. The pipeline holds.
- Back-to-back unmapped transfers: ERR1, ERR2, ERR1, ERR2, with no OK gap.

## Structure
- Shared package ahb_bridge_pkg:
  - HTRANS constants (IDLE, BUSY, NONSEQ, SEQ).
  - HRESP constants (OKAY, ERROR).
  - Error FSM state typedef.
- Sub-module ahb_addr_decode: parameters ADDR_W, NUM_SLV, BASE_ADDR, SLV_AW; outputs hit and one-hot sel. Reused by the APB controller for PSEL.

## Test plan
- Reset with h_addr = 0x8000_0010, h_trans = 10 -> all pipeline regs 0, h_resp = 00; valid = 1, tempsel = 001 once h_readyin = 1.
- Defaults, NONSEQ write at 0x8400_0004, h_readyout = 1, wdata 0xA5A5_0001 -> tempsel = 010, valid = 1. Next edge h_addr1 = 0x8400_0004, writereg = 1. Following edge h_wdata2 = 0xA5A5_0001.
- NONSEQ at 0x8C00_0000 (one past map) -> valid = 0, tempsel = 000. Next cycle h_resp = 01, h_ready_o = 0. Then h_resp = 01, h_ready_o = 1. Then OKAY.
- NONSEQ at 0x7FFF_FFFC, then 0xFFFF_FFFC with NUM_SLV = 16, SLV_AW = 27 -> first errors; second hits slave 15 with no wrap.
- h_readyout = 0 for 3 cycles during a NONSEQ write at 0x8800_0000 -> h_addr1/2 and h_wdata1/2 hold. Update on first cycle h_readyout = 1.
- Assert h_reset during ERR1 -> h_resp = 00 and h_ready_o = h_readyout immediately (async). FSM in OK after release.
